// File: rtl/pc_gen_if.sv
// Fetch-side bus of the PC generator: pipeline control in, fetch address and status out.
// The master modport is the pipeline-control side; the slave modport is pc_gen itself.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               branch_flag;
    logic [ADDR_W-1:0]  branch_target;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               redirect_pending;
    logic               pc_misaligned;

    modport master (
        output stall, branch_flag, branch_target, flush, new_pc,
        input  pc, ce, redirect_pending, pc_misaligned
    );

    modport slave (
        input  stall, branch_flag, branch_target, flush, new_pc,
        output pc, ce, redirect_pending, pc_misaligned
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-address generator: sequential PC with branch and flush redirects, plus a
// one-entry buffer that holds a branch raised while the PC stage is stalled.
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int                INST_BYTES = 4,
    parameter int                STALL_W    = 6
) (
    input logic     clk,
    input logic     rst,
    pc_gen_if.slave bus
);
    typedef enum logic {S_RESET, S_RUN} state_e;

    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pend_target_q;
    logic              ce_q;
    logic              pend_valid_q;
    logic              pc_stall;
    logic              unused_stall_hi;

    assign pc_stall        = bus.stall[0];
    assign unused_stall_hi = ^bus.stall;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every branch
        // below sees the pre-edge values of pc_q and pend_valid_q.
        if (rst) begin
            state_q      <= S_RESET;
            ce_q         <= 1'b0;
            pc_q         <= RESET_VEC;
            pend_valid_q <= 1'b0;
            // NOTE: pend_target_q is left out of reset on purpose; it is only
            // read while pend_valid_q is set, so its contents are don't-care.
        end else begin
            case (state_q)
                S_RESET: begin
                    state_q <= S_RUN;
                    ce_q    <= 1'b1;
                end
                S_RUN: begin
                    ce_q <= 1'b1;
                    if (bus.flush) begin
                        pc_q         <= bus.new_pc;
                        pend_valid_q <= 1'b0;
                    end else if (pc_stall) begin
                        // Newest branch wins; an older buffered one is overwritten.
                        if (bus.branch_flag) begin
                            pend_valid_q  <= 1'b1;
                            pend_target_q <= bus.branch_target;
                        end
                    end else if (bus.branch_flag) begin
                        pc_q         <= bus.branch_target;
                        pend_valid_q <= 1'b0;
                    end else if (pend_valid_q) begin
                        pc_q         <= pend_target_q;
                        pend_valid_q <= 1'b0;
                    end else begin
                        pc_q <= pc_q + INC;
                    end
                end
                default: begin
                    state_q <= S_RESET;
                    ce_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc               = pc_q;
    assign bus.ce               = ce_q;
    assign bus.redirect_pending = pend_valid_q;
    // Misaligned targets are fetched as given; this flag only reports them.
    assign bus.pc_misaligned    = ce_q & ((pc_q & ALIGN_MASK) != '0);
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed boot/stall/branch/flush/wrap/reset steps,
// then randomized traffic against a behavioural fetch-address model.
module tb_pc_gen;
    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus  ();
    pc_gen_if #(.ADDR_W(8),  .STALL_W(6)) bus8 ();

    pc_gen #(.ADDR_W(32), .RESET_VEC(RV), .INST_BYTES(4), .STALL_W(6)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    pc_gen #(.ADDR_W(8), .RESET_VEC(8'h00), .INST_BYTES(4), .STALL_W(6)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: is the fetcher running, where is it, and what redirect is waiting.
    bit          m_run = 1'b0;
    logic [31:0] m_pc  = RV;
    logic [31:0] m_pend[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_run = 1'b0;
            m_pc  = RV;
            m_pend.delete();
        end else if (!m_run) begin
            m_run = 1'b1;
        end else if (bus.flush) begin
            m_pc = bus.new_pc;
            m_pend.delete();
        end else if (bus.stall[0]) begin
            if (bus.branch_flag) begin
                m_pend.delete();
                m_pend.push_back(bus.branch_target);
            end
        end else if (bus.branch_flag) begin
            m_pc = bus.branch_target;
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front();
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // One clock: model sees the same inputs as the DUT at the edge; outputs sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("pc", bus.pc, m_pc);
        check("ce", 32'(bus.ce), 32'(m_run));
        check("pending", 32'(bus.redirect_pending), 32'(m_pend.size() != 0));
        check("misaligned", 32'(bus.pc_misaligned), 32'(m_run && (m_pc[1:0] != 2'b00)));
    endtask

    task automatic drive(input logic [5:0] s, input logic b, input logic [31:0] bt,
                         input logic f, input logic [31:0] np);
        bus.stall         = s;
        bus.branch_flag   = b;
        bus.branch_target = bt;
        bus.flush         = f;
        bus.new_pc        = np;
    endtask

    initial begin
        rst = 1'b1;
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus8.stall = '0; bus8.branch_flag = 1'b0; bus8.branch_target = '0;
        bus8.flush = 1'b0; bus8.new_pc = '0;

        // Boot: three reset cycles, then first fetch at the reset vector.
        repeat (3) cycle();
        check("reset_ce", 32'(bus.ce), 32'd0);
        rst = 1'b0;
        cycle();
        check("boot_pc", bus.pc, RV);
        check("boot_ce", 32'(bus.ce), 32'd1);
        cycle();
        check("boot_pc1", bus.pc, 32'hBFC0_0004);
        cycle();
        check("boot_pc2", bus.pc, 32'hBFC0_0008);

        // Stall holds pc; upper stall bits are ignored.
        drive(6'b0, 1'b1, 32'h10, 1'b0, 32'h0);  cycle();
        drive(6'b000001, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(); check("stall_hold0", bus.pc, 32'h10);
        cycle(); check("stall_hold1", bus.pc, 32'h10);
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);      cycle(); check("stall_rel", bus.pc, 32'h14);
        drive(6'b111110, 1'b0, 32'h0, 1'b0, 32'h0); cycle(); check("stall_hi", bus.pc, 32'h18);

        // Unstalled branch: one-cycle latency.
        drive(6'b0, 1'b1, 32'h40, 1'b0, 32'h0);  cycle();
        drive(6'b0, 1'b1, 32'h200, 1'b0, 32'h0); cycle(); check("br_tgt", bus.pc, 32'h200);
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);   cycle(); check("br_seq", bus.pc, 32'h204);

        // Buffered branch: newer one overwrites, applied on release.
        drive(6'b0, 1'b1, 32'h80, 1'b0, 32'h0);  cycle();
        drive(6'b1, 1'b1, 32'h300, 1'b0, 32'h0); cycle();
        check("buf_pc0", bus.pc, 32'h80); check("buf_pend0", 32'(bus.redirect_pending), 32'd1);
        drive(6'b1, 1'b1, 32'h400, 1'b0, 32'h0); cycle();
        check("buf_pc1", bus.pc, 32'h80); check("buf_pend1", 32'(bus.redirect_pending), 32'd1);
        drive(6'b1, 1'b0, 32'h0, 1'b0, 32'h0);   cycle(); check("buf_pc2", bus.pc, 32'h80);
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);   cycle();
        check("buf_rel", bus.pc, 32'h400); check("buf_clr", 32'(bus.redirect_pending), 32'd0);
        cycle(); check("buf_seq", bus.pc, 32'h404);

        // Flush beats stall, same-cycle branch and the pending buffer.
        drive(6'b1, 1'b1, 32'h600, 1'b0, 32'h0);   cycle();
        drive(6'b1, 1'b1, 32'h500, 1'b1, 32'h180); cycle();
        check("fl_pc", bus.pc, 32'h180); check("fl_pend", 32'(bus.redirect_pending), 32'd0);
        drive(6'b1, 1'b0, 32'h0, 1'b0, 32'h0);     cycle(); check("fl_hold", bus.pc, 32'h180);
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);     cycle(); check("fl_seq", bus.pc, 32'h184);
        drive(6'b0, 1'b1, 32'h202, 1'b0, 32'h0);   cycle();
        check("mis_pc", bus.pc, 32'h202); check("mis_flag", 32'(bus.pc_misaligned), 32'd1);
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);     cycle();
        check("mis_seq", bus.pc, 32'h206); check("mis_keep", 32'(bus.pc_misaligned), 32'd1);

        // 8-bit instance wraps from FC to 00.
        bus8.branch_flag = 1'b1; bus8.branch_target = 8'hFC; cycle();
        check("wrap_fc", 32'(bus8.pc), 32'h0000_00FC);
        bus8.branch_flag = 1'b0; cycle();
        check("wrap_00", 32'(bus8.pc), 32'h0000_0000);

        // Reset with a redirect pending: buffer is lost.
        drive(6'b1, 1'b1, 32'h700, 1'b0, 32'h0); cycle();
        check("rst_pend_set", 32'(bus.redirect_pending), 32'd1);
        rst = 1'b1; cycle();
        check("rst_ce", 32'(bus.ce), 32'd0); check("rst_pc", bus.pc, RV);
        check("rst_pend", 32'(bus.redirect_pending), 32'd0);
        rst = 1'b0; drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0); cycle();
        check("rst_boot", bus.pc, RV);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive(6'($urandom()) & (($urandom_range(0, 99) < 30) ? 6'h3F : 6'h3E),
                  ($urandom_range(0, 99) < 20), $urandom(),
                  ($urandom_range(0, 99) < 5), $urandom());
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch-address generator for the in-order pipeline. Successor to the fixed-width, increment-only PC register; drives `pc` and `ce` into instruction ROM / IF stage.
- Adds a configurable reset vector, width, instruction size and stall-vector width.
- Adds branch/jump redirect, exception-flush redirect, and a one-entry pending-redirect buffer that holds a branch raised while IF is stalled.
- Flags misaligned fetch addresses.

Parameters:
- ADDR_W, 32, width of pc and all target buses.
- RESET_VEC, 32'h0000_0000, first fetch address after reset (ADDR_W bits).
- INST_BYTES, 4, sequential increment in bytes; power of two, ≥1.
- STALL_W, 6, width of pipeline stall vector; only bit 0 (PC stage) is used here.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  pipeline stall vector; stall[0]=1 holds pc.
- branch_flag  in  1  ID-stage redirect request, valid this cycle.
- branch_target  in  ADDR_W  redirect address qualified by branch_flag.
- flush  in  1  exception/eret flush from control; overrides everything except rst.
- new_pc  in  ADDR_W  handler/return address qualified by flush.
- pc  out  ADDR_W  current fetch address (register).
- ce  out  1  instruction memory chip enable (register).
- redirect_pending  out  1  pending-redirect buffer occupied (register).
- pc_misaligned  out  1  combinational: ce & (pc[log2(INST_BYTES)-1:0] != 0); constant 0 when INST_BYTES=1.

Behaviour:
- Reset and clock polarity (decided): one clock, clk; reset rst is synchronous and active-high.
- Internal state: FSM {S_RESET, S_RUN}; pend_valid (drives redirect_pending); pend_target[ADDR_W].
- rst=1 at an edge, regardless of other inputs:
  - state<=S_RESET, ce<=0, pc<=RESET_VEC.
  - pend_valid<=0; pend_target contents don't-care.
- S_RESET with rst=0 at an edge:
  - state<=S_RUN, ce<=1.
  - pc stays RESET_VEC, so the first fetch is RESET_VEC on the first cycle ce=1.
  - flush, branch_flag and stall are ignored in S_RESET.
- S_RUN, at each edge, first matching rule wins:
  1. flush=1: pc<=new_pc, pend_valid<=0. Applies even when stall[0]=1. A same-cycle branch_flag is discarded.
  2. stall[0]=1: pc holds.
     - If branch_flag=1: pend_valid<=1, pend_target<=branch_target. A newer branch overwrites an older pending one.
     - Otherwise the pend state holds.
  3. stall[0]=0 and branch_flag=1: pc<=branch_target, pend_valid<=0. A live branch beats a stale pending one.
  4. stall[0]=0 and pend_valid=1: pc<=pend_target, pend_valid<=0.
  5. Otherwise: pc<=pc+INST_BYTES, modulo 2^ADDR_W. All-ones region wraps to low addresses with no flag.
- Redirect latency: exactly one cycle. A target presented in cycle N appears on pc in cycle N+1, or on the first unstalled edge if buffered.
- ce is 1 in every S_RUN cycle; stall does not deassert ce.
- Misaligned targets are loaded as given, never rounded. pc_misaligned reports them; sequential increments keep the misalignment.
- stall bits [STALL_W-1:1] are ignored.
- Reset mid-operation (any state, pending buffer full or not): next cycle is S_RESET, ce=0, pc=RESET_VEC, buffer empty. The pending redirect is lost.

Test Plan:
- Reset/boot, RESET_VEC=32'hBFC0_0000: hold rst 3 cycles, release.
  - Cycle after release: ce=1, pc=BFC00000.
  - Following cycles: BFC00004, BFC00008.
- Stall: stall=6'b000001 for 2 cycles at pc=0x10 → pc stays 0x10 both cycles, then 0x14. Setting stall=6'b111110 with stall[0]=0 still increments.
- Branch, unstalled: branch_flag=1, branch_target=0x200 at pc=0x40 → next pc=0x200, then 0x204.
- Buffered branch:
  - With stall[0]=1 and pc=0x80, pulse branch 0x300; one cycle later, still stalled, pulse branch 0x400.
  - Required: redirect_pending=1 and pc=0x80 throughout the stall.
  - On release: pc=0x400, redirect_pending=0, then 0x404.
- Flush priority:
  - flush=1, new_pc=0x180 with branch_flag=1 (0x500), stall[0]=1, and a pending redirect → pc=0x180, redirect_pending=0, then 0x184 once unstalled.
  - Then branch_target=0x202 → pc=0x202, pc_misaligned=1.
- Wrap and reset mid-stream:
  - ADDR_W=8, INST_BYTES=4, pc=8'hFC → 8'h00.
  - Assert rst while redirect_pending=1 → ce=0, pc=RESET_VEC, redirect_pending=0 on the next cycle.
